// File: rtl/ret_stack_pkg.sv
// Shared constants and helpers for the ret_stack return-address stack.
package ret_stack_pkg;

   localparam int NBITS_DEF  = 8;
   localparam int SDEPTH_DEF = 8;

   function automatic int depth_w(input int sdepth);
      return $clog2(sdepth + 1);
   endfunction

endpackage

// File: rtl/ret_stack_ram.sv
// Spill storage for ret_stack: entries below the TOS register.
// Synchronous write, asynchronous read, no reset.
module ret_stack_ram
   import ret_stack_pkg::*;
#(
   parameter int NBITS   = NBITS_DEF,
   parameter int ENTRIES = SDEPTH_DEF - 1,
   parameter int AW      = 3
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [NBITS-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [NBITS-1:0] rdata_o
);

   logic [NBITS-1:0] mem_q [ENTRIES];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_stack.sv
// Hardware return-address stack (LIFO) with the top held in a register.
// Define RET_STACK_WRAP_EN to make push-while-full overwrite the oldest entry.
module ret_stack
   import ret_stack_pkg::*;
#(
   parameter int NBITS  = NBITS_DEF,
   parameter int SDEPTH = SDEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [NBITS-1:0]             data_in,
   output logic [NBITS-1:0]             data_out,
   output logic                         empty,
   output logic                         full,
   output logic                         ovf,
   output logic                         unf,
   output logic [depth_w(SDEPTH)-1:0]   depth
);

   localparam int DW = depth_w(SDEPTH);
   localparam int AW = (SDEPTH > 2) ? $clog2(SDEPTH - 1) : 1;
   localparam logic [AW-1:0] LAST = AW'(SDEPTH - 2);
   localparam logic [DW-1:0] FULL_CNT = DW'(SDEPTH);

   logic [NBITS-1:0] tos_q, tos_d;
   logic [AW-1:0]    wp_q, wp_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             we;
   logic [AW-1:0]    wp_inc, wp_dec;
   logic [NBITS-1:0] rdata;

   // Explicit wrap compares keep non-power-of-2 array sizes correct.
   assign wp_inc = (wp_q == LAST) ? '0 : wp_q + 1'b1;
   assign wp_dec = (wp_q == '0) ? LAST : wp_q - 1'b1;

   assign empty    = (depth_q == '0);
   assign full     = (depth_q == FULL_CNT);
   assign data_out = tos_q;
   assign depth    = depth_q;
   assign ovf      = ovf_q;
   assign unf      = unf_q;

   ret_stack_ram #(
      .NBITS   (NBITS),
      .ENTRIES (SDEPTH - 1),
      .AW      (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (wp_q),
      .wdata_i (tos_q),
      .raddr_i (wp_dec),
      .rdata_o (rdata)
   );

   always_comb begin
      tos_d   = tos_q;
      wp_d    = wp_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      we      = 1'b0;
      if (push && pop && !empty) begin
         tos_d = data_in;
      end else if (push) begin
         if (!full) begin
            tos_d   = data_in;
            depth_d = depth_q + 1'b1;
            if (!empty) begin
               we   = 1'b1;
               wp_d = wp_inc;
            end
         end else begin
            ovf_d = 1'b1;
`ifdef RET_STACK_WRAP_EN
            // wp already points at the oldest entry when the array is full.
            we    = 1'b1;
            tos_d = data_in;
            wp_d  = wp_inc;
`else
`endif
         end
      end else if (pop) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            depth_d = depth_q - 1'b1;
            if (depth_q > DW'(1)) begin
               tos_d = rdata;
               wp_d  = wp_dec;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tos_q   <= '0;
         wp_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         tos_q   <= tos_d;
         wp_q    <= wp_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

endmodule

// File: tb/tb_ret_stack.sv
// Randomized and directed bench for ret_stack against a queue-based LIFO model.
module tb_ret_stack;

   localparam int NBITS  = 8;
   localparam int SDEPTH = 8;
   localparam int DW     = $clog2(SDEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [NBITS-1:0] data_in = '0;
   logic [NBITS-1:0] data_out;
   logic             empty, full, ovf, unf;
   logic [DW-1:0]    depth;

   int n_vec = 0;
   int n_err = 0;

   int m_q[$];
   bit m_ovf = 0;
   bit m_unf = 0;

   ret_stack #(.NBITS(NBITS), .SDEPTH(SDEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .data_in  (data_in),
      .data_out (data_out),
      .empty    (empty),
      .full     (full),
      .ovf      (ovf),
      .unf      (unf),
      .depth    (depth)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit p, input bit o, input int d);
      if (p && o && m_q.size() > 0) begin
         m_q[m_q.size()-1] = d;
      end else if (p) begin
         if (m_q.size() < SDEPTH) begin
            m_q.push_back(d);
         end else begin
            m_ovf = 1;
`ifdef RET_STACK_WRAP_EN
            void'(m_q.pop_front());
            m_q.push_back(d);
`endif
         end
      end else if (o) begin
         if (m_q.size() == 0) m_unf = 1;
         else void'(m_q.pop_back());
      end
   endtask

   task automatic compare_all();
      chk("depth", 32'(depth), 32'(m_q.size()));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("full",  32'(full),  32'(m_q.size() == SDEPTH));
      chk("ovf",   32'(ovf),   32'(m_ovf));
      chk("unf",   32'(unf),   32'(m_unf));
      if (m_q.size() > 0) chk("data_out", 32'(data_out), 32'(m_q[m_q.size()-1]));
   endtask

   task automatic apply(input bit p, input bit o, input int d);
      push    = p;
      pop     = o;
      data_in = d[NBITS-1:0];
      @(posedge clk);
      #1;
      model_step(p, o, d);
      compare_all();
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_dout"},  32'(data_out), 32'h0);
      chk({tag, "_depth"}, 32'(depth), 32'h0);
      chk({tag, "_empty"}, 32'(empty), 32'h1);
      chk({tag, "_full"},  32'(full), 32'h0);
      chk({tag, "_ovf"},   32'(ovf), 32'h0);
      chk({tag, "_unf"},   32'(unf), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_q.delete();
      m_ovf = 0;
      m_unf = 0;
   endtask

   initial begin
      int pr;
      // Reset then idle
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) apply(0, 0, 0);
      check_reset_vals("rst_idle");

      // LIFO ordering
      apply(1, 0, 'h10);
      apply(1, 0, 'h20);
      apply(1, 0, 'h30);
      chk("lifo_top", 32'(data_out), 32'h30);
      apply(0, 1, 0);
      chk("lifo_pop1", 32'(data_out), 32'h20);
      apply(0, 1, 0);
      chk("lifo_pop2", 32'(data_out), 32'h10);
      apply(0, 1, 0);
      chk("lifo_empty", 32'(empty), 32'h1);

      // Fill, then push while full
      for (int i = 1; i <= SDEPTH; i++) apply(1, 0, i);
      chk("fill_full", 32'(full), 32'h1);
      apply(1, 0, 'h09);
`ifdef RET_STACK_WRAP_EN
      chk("wrap_top", 32'(data_out), 32'h09);
`else
      chk("drop_top", 32'(data_out), 32'h08);
`endif
      chk("full_ovf", 32'(ovf), 32'h1);
      for (int i = 0; i < SDEPTH; i++) apply(0, 1, 0);
      do_reset();

      // Replace at depth 2
      apply(1, 0, 'h11);
      apply(1, 0, 'h22);
      apply(1, 1, 'h33);
      chk("repl_top", 32'(data_out), 32'h33);
      chk("repl_depth", 32'(depth), 32'h2);
      apply(0, 1, 0);
      chk("repl_pop", 32'(data_out), 32'h11);
      apply(0, 1, 0);

      // Underflow stickiness; push+pop at depth 0 acts as push
      apply(0, 1, 0);
      repeat (10) apply(0, 0, 0);
      chk("unf_sticky", 32'(unf), 32'h1);
      do_reset();
      #1;
      chk("unf_cleared", 32'(unf), 32'h0);
      apply(1, 1, 'h5A);
      chk("pp_empty_unf", 32'(unf), 32'h0);
      apply(0, 1, 0);

      // Asynchronous reset mid-sequence at depth 4
      for (int i = 0; i < 4; i++) apply(1, 0, 'hA0 + i);
      chk("pre_arst_depth", 32'(depth), 32'h4);
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("arst");
      #2;
      rst = 1'b0;
      m_q.delete();
      m_ovf = 0;
      m_unf = 0;
      apply(1, 0, 'hC3);
      chk("post_arst_top", 32'(data_out), 32'hC3);
      chk("post_arst_depth", 32'(depth), 32'h1);

      // Randomized phases with shifting push bias
      for (int ph = 0; ph < 6; ph++) begin
         pr = (ph % 2 == 0) ? 75 : 25;
         for (int i = 0; i < 120; i++) begin
            int r;
            r = $urandom_range(99);
            if ($urandom_range(9) == 0) apply(1, 1, $urandom_range(255));
            else if (r < pr) apply(1, 0, $urandom_range(255));
            else apply(0, 1, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
